// File: rtl/instr_issue_queue.sv
// Instruction issue queue: buffers host instructions, issues them one at a time to the processor and waits for done.
// Latency: push into an empty idle queue drops instruct_sig 2 edges later; done sampled raises instruct_sig next edge.
// Backpressure: in_ready falls when the FIFO is full and pushes are ignored; ISSUE_TIMEOUT_EN enables the WAIT abort.

module issue_fifo #(
    parameter int W     = 34,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_vld,
    input  logic [W-1:0]             push_dat,
    output logic                     push_rdy,
    input  logic                     pop_rdy,
    output logic                     pop_vld,
    output logic [W-1:0]             pop_dat,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push;
    logic          pop;

    assign push_rdy = (level != FULL_LVL);
    assign pop_vld  = (level != '0);
    assign push     = push_vld && push_rdy;
    assign pop      = pop_rdy && pop_vld;
    assign pop_dat  = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two; level tracks occupancy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    // Storage needs no reset: an entry is only read after it has been written
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_dat;
    end
endmodule

module instr_issue_queue #(
    parameter int DEPTH          = 8,
    parameter int GAP_CYCLES     = 2,
    parameter int WR_HOLD        = 2,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [33:0]              in_instr,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [33:0]              instruct,
    output logic                     instruct_sig,
    input  logic                     output_sig,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic [15:0]              issued_count,
    output logic                     timeout_err
);
    localparam int CMAX = (TIMEOUT_CYCLES > WR_HOLD)
                        ? ((TIMEOUT_CYCLES > GAP_CYCLES) ? TIMEOUT_CYCLES : GAP_CYCLES)
                        : ((WR_HOLD > GAP_CYCLES) ? WR_HOLD : GAP_CYCLES);
    localparam int CW   = $clog2(CMAX + 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_GAP} state_t;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cyc_cnt;
    logic          fifo_nempty;
    logic [33:0]   fifo_head;
    logic          pop;
    logic          complete;
    logic          wr_op;
    logic          hold_done;
    logic          gap_done;

    issue_fifo #(.W(34), .DEPTH(DEPTH)) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push_vld (in_valid),
        .push_dat (in_instr),
        .push_rdy (in_ready),
        .pop_rdy  (pop),
        .pop_vld  (fifo_nempty),
        .pop_dat  (fifo_head),
        .level    (fifo_level)
    );

    // Opcode 000 is a write that never reports done, so it completes on a fixed hold
    assign wr_op     = (instruct[33:31] == 3'b000);
    assign hold_done = (cyc_cnt == CW'(WR_HOLD - 1));
    assign gap_done  = (cyc_cnt == CW'(GAP_CYCLES - 1));
    assign busy      = (state != S_IDLE) || fifo_nempty;

`ifdef ISSUE_TIMEOUT_EN
    logic to_hit;
    assign to_hit = (cyc_cnt == CW'(TIMEOUT_CYCLES - 1));
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Next-state: ISSUE is a single cycle so the stale echo of output_sig is never sampled
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (fifo_nempty) state_nxt = S_ISSUE;
            S_ISSUE: state_nxt = S_WAIT;
            S_WAIT: begin
                if (wr_op) begin
                    if (hold_done) state_nxt = S_GAP;
                end else if (output_sig) begin
                    state_nxt = S_GAP;
                end
`ifdef ISSUE_TIMEOUT_EN
                else if (to_hit) begin
                    state_nxt = S_GAP;
                end
`endif
            end
            S_GAP:   if (gap_done) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Output decode: pop the head when leaving IDLE, flag a genuine completion in WAIT
    always_comb begin
        pop      = 1'b0;
        complete = 1'b0;
        case (state)
            S_IDLE:  pop = fifo_nempty;
            S_WAIT:  complete = wr_op ? hold_done : output_sig;
            default: ;
        endcase
    end

    // Cycle counter restarts on every state change; shared by WAIT hold/timeout and GAP
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                     cyc_cnt <= '0;
        else if (state_nxt != state) cyc_cnt <= '0;
        else                         cyc_cnt <= cyc_cnt + 1'b1;
    end

    // Registered processor-facing outputs and completion counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instruct     <= '0;
            instruct_sig <= 1'b1;
            issued_count <= '0;
        end else begin
            if (pop)      instruct <= fifo_head;
            instruct_sig <= (state_nxt == S_IDLE) || (state_nxt == S_GAP);
            if (complete) issued_count <= issued_count + 16'd1;
        end
    end

`ifdef ISSUE_TIMEOUT_EN
    // Sticky abort flag: WAIT ran out of cycles without a done
    always_ff @(posedge clk or posedge rst) begin
        if (rst) timeout_err <= 1'b0;
        else if ((state == S_WAIT) && !wr_op && !output_sig && to_hit) timeout_err <= 1'b1;
    end
`else
    assign timeout_err = 1'b0;
`endif
endmodule

// File: tb/tb_instr_issue_queue.sv
module tb_instr_issue_queue;
    localparam int DEPTH = 8;
    localparam int GAP   = 2;
    localparam int WRH   = 2;
    localparam int TO    = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic [33:0] in_instr;
    logic        in_valid;
    logic        in_ready;
    logic [33:0] instruct;
    logic        instruct_sig;
    logic        output_sig;
    logic        busy;
    logic [3:0]  fifo_level;
    logic [15:0] issued_count;
    logic        timeout_err;

    always #5 clk = ~clk;

    instr_issue_queue #(.DEPTH(DEPTH), .GAP_CYCLES(GAP), .WR_HOLD(WRH), .TIMEOUT_CYCLES(TO)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_instr     (in_instr),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .instruct     (instruct),
        .instruct_sig (instruct_sig),
        .output_sig   (output_sig),
        .busy         (busy),
        .fifo_level   (fifo_level),
        .issued_count (issued_count),
        .timeout_err  (timeout_err)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    logic [33:0] exp_q[$];
    logic [33:0] last_issued;
    int          exp_count;
    bit          exp_terr;
    bit          pend_push;
    logic [33:0] pend_dat;
    bit          prev_sig;
    int          low_cnt;
    int          high_cnt;
    int          proc_delay;
    bit [2:0]    cur_op;
    int          exp_len;
    bit          aborted;
    int          rel_seen = 0;

    // Stimulus controls read by the processor model
    bit stall_mode  = 1'b0;
    int force_delay = 0;
    int release_cnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor, scoreboard and processor model: everything observed on the falling edge
    initial begin
        output_sig = 1'b1;
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_q.delete();
                last_issued = '0;
                exp_count   = 0;
                exp_terr    = 1'b0;
                pend_push   = 1'b0;
                prev_sig    = 1'b1;
                low_cnt     = 0;
                high_cnt    = 1000;
                cur_op      = 3'b000;
                proc_delay  = 1;
                output_sig  = 1'b1;
            end else begin
                // Issue: head of the model queue must appear, after a full gap
                if (prev_sig && !instruct_sig) begin
                    check("gap_len_ok", 64'(high_cnt >= GAP + 1), 64'd1);
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL issue_from_empty: instruct_sig fell with model queue empty (t=%0t)", $time);
                    end else begin
                        last_issued = exp_q.pop_front();
                        cur_op      = last_issued[33:31];
                    end
                    proc_delay = (force_delay > 0) ? force_delay
                               : (stall_mode ? 1000000 : int'($urandom_range(1, 4)));
                    low_cnt = 0;
                end
                // Completion: low time is ISSUE plus the WAIT length implied by opcode/done/timeout
                if (!prev_sig && instruct_sig) begin
                    aborted = 1'b0;
                    if (cur_op == 3'b000) exp_len = 1 + WRH;
                    else begin
                        exp_len = 1 + proc_delay;
`ifdef ISSUE_TIMEOUT_EN
                        if (proc_delay > TO) begin
                            exp_len = 1 + TO;
                            aborted = 1'b1;
                        end
`endif
                    end
                    check("wait_len", 64'(low_cnt), 64'(exp_len));
                    if (aborted) exp_terr = 1'b1;
                    else         exp_count++;
                    check("issued_count", 64'(issued_count), 64'(exp_count[15:0]));
                    high_cnt = 0;
                end
                if (!instruct_sig) low_cnt++;
                else               high_cnt++;

                check("instruct", 64'(instruct), 64'(last_issued));
                if (pend_push) exp_q.push_back(pend_dat);
                check("fifo_level", 64'(fifo_level), 64'(exp_q.size()));
                check("in_ready", 64'(in_ready), 64'(exp_q.size() < DEPTH));
                check("busy", 64'(busy), 64'(!instruct_sig || exp_q.size() != 0 || high_cnt <= GAP));
                check("timeout_err", 64'(timeout_err), 64'(exp_terr));
                pend_push = in_valid && (exp_q.size() < DEPTH);
                pend_dat  = in_instr;
                prev_sig  = instruct_sig;

                // Processor: echoes 1 while idle, keeps the stale echo in the first low cycle,
                // then raises done once the chosen delay of WAIT cycles has elapsed
                if (instruct_sig) output_sig = 1'b1;
                else if (low_cnt > 1) begin
                    if (release_cnt != rel_seen) begin
                        rel_seen   = release_cnt;
                        proc_delay = low_cnt;
                    end
                    output_sig = (low_cnt - 1 >= proc_delay);
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic drive_cycle();
        @(posedge clk);
        #2;
    endtask

    task automatic push_one(input logic [33:0] d);
        in_valid = 1'b1;
        in_instr = d;
        drive_cycle();
        in_valid = 1'b0;
    endtask

    function automatic logic [33:0] rnd_instr();
        logic [31:0] r;
        logic [2:0]  op;
        r  = $urandom;
        op = ($urandom_range(0, 3) == 0) ? 3'b000 : 3'($urandom_range(1, 7));
        return {op, r[30:0]};
    endfunction

    task automatic wait_idle();
        int k;
        k = 0;
        drive_cycle();
        drive_cycle();
        while (busy && k < 3000) begin
            drive_cycle();
            k++;
        end
        check("idle_reached", 64'(busy), 64'd0);
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_instr = '0;
        #12;
        check("rst_sig", 64'(instruct_sig), 64'd1);
        check("rst_ready", 64'(in_ready), 64'd1);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_level", 64'(fifo_level), 64'd0);
        check("rst_count", 64'(issued_count), 64'd0);
        check("rst_instruct", 64'(instruct), 64'd0);
        check("rst_terr", 64'(timeout_err), 64'd0);
        drive_cycle();
        rst = 1'b0;
        drive_cycle();
        drive_cycle();

        // Write opcode into an empty idle queue: fixed hold, exact issue latency
        push_one(34'h0_0001_1234);
        check("t1_sig_before_issue", 64'(instruct_sig), 64'd1);
        drive_cycle();
        check("t1_sig_low_2_edges", 64'(instruct_sig), 64'd0);
        check("t1_instruct", 64'(instruct), 64'h0_0001_1234);
        wait_idle();
        check("t1_count", 64'(issued_count), 64'd1);

        // Processor-completed opcode, done 3 WAIT cycles after issue
        force_delay = 3;
        push_one({3'b001, 31'h0ABC_DEF0});
        wait_idle();
        force_delay = 0;
        check("t2_count", 64'(issued_count), 64'd2);

        // Fill while the processor stalls: 8 buffered + 1 in flight, 10th dropped
        stall_mode = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            in_valid = 1'b1;
            in_instr = {3'b001, 31'(i)};
            drive_cycle();
        end
        check("t3_ready_low", 64'(in_ready), 64'd0);
        check("t3_level_full", 64'(fifo_level), 64'd8);
        in_instr = {3'b001, 31'd10};
        drive_cycle();
        in_valid = 1'b0;
        check("t3_drop_level", 64'(fifo_level), 64'd8);
        stall_mode = 1'b0;
        release_cnt++;
        wait_idle();
        check("t3_count", 64'(issued_count), 64'd11);

        // Level 3 with stalled processor, then keep pushing while it drains
        stall_mode = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_instr = {3'b010, 31'(100 + i)};
            drive_cycle();
        end
        in_valid = 1'b0;
        check("t4_level3", 64'(fifo_level), 64'd3);
        stall_mode = 1'b0;
        release_cnt++;
        for (int i = 0; i < 12; i++) begin
            in_valid = 1'b1;
            in_instr = {3'b011, 31'(200 + i)};
            drive_cycle();
        end
        in_valid = 1'b0;
        wait_idle();

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            in_valid = ($urandom_range(0, 2) == 0);
            in_instr = rnd_instr();
            drive_cycle();
        end
        in_valid = 1'b0;
        wait_idle();

        // Asynchronous reset in the middle of WAIT
        stall_mode = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_instr = {3'b110, 31'(300 + i)};
            drive_cycle();
        end
        in_valid = 1'b0;
        drive_cycle();
        drive_cycle();
        check("t5_in_wait", 64'(instruct_sig), 64'd0);
        #1;
        rst = 1'b1;
        #1;
        check("t5_sig", 64'(instruct_sig), 64'd1);
        check("t5_level", 64'(fifo_level), 64'd0);
        check("t5_count", 64'(issued_count), 64'd0);
        check("t5_busy", 64'(busy), 64'd0);
        check("t5_instruct", 64'(instruct), 64'd0);
        drive_cycle();
        rst        = 1'b0;
        stall_mode = 1'b0;
        drive_cycle();
        drive_cycle();

`ifdef ISSUE_TIMEOUT_EN
        // Done never arrives: abort after the timeout, next instruction still issues
        stall_mode = 1'b1;
        push_one({3'b101, 31'h0000_0555});
        drive_cycle();
        drive_cycle();
        stall_mode = 1'b0;
        push_one({3'b001, 31'h0000_0666});
        wait_idle();
        check("t6_terr", 64'(timeout_err), 64'd1);
        check("t6_count", 64'(issued_count), 64'd1);
`endif

        for (int i = 0; i < 100; i++) begin
            in_valid = ($urandom_range(0, 1) == 0);
            in_instr = rnd_instr();
            drive_cycle();
        end
        in_valid = 1'b0;
        wait_idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
